// File: rtl/glycemic_index_scheduler_if.sv
// rtl/glycemic_index_scheduler_if.sv - sensor request and glycemic-index result bundle
interface glycemic_index_scheduler_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]   req_valid;
    logic [8*NUM_CH-1:0] req_data;
    logic [NUM_CH-1:0]   req_ready;
    logic                gi_valid;
    logic [3:0]          gi_value;
    logic [1:0]          gi_channel;
    logic                busy;
    logic [NUM_CH-1:0]   alarm;

    modport master (
        output req_valid, req_data,
        input  req_ready, gi_valid, gi_value, gi_channel, busy, alarm
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, gi_valid, gi_value, gi_channel, busy, alarm
    );
endinterface

// File: rtl/glycemic_index_scheduler.sv
// rtl/glycemic_index_scheduler.sv - round-robin shared bit-serial glycemic-index engine
// Optional per-channel sustained-high alarm counters are built when GI_ALARM_EN is defined.
module glycemic_index_scheduler #(
    parameter int        NUM_CH       = 2,
    parameter logic [3:0] ALARM_THRESH = 4'd6,
    parameter int        ALARM_COUNT  = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    glycemic_index_scheduler_if.slave      bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_last_grant;
    logic [7:0]  r_shift;
    logic [3:0]  r_acc;
    logic [2:0]  r_cnt;
    logic [3:0]  r_gi_value;
    logic [1:0]  r_gi_channel;

    logic        w_any;
    logic [1:0]  w_winner;
    logic [7:0]  w_sample;
    logic [7:0]  w_abs;
    logic        w_fire;

    // Search starts just after the last grant and wraps, giving strict round-robin.
    always_comb begin
        w_any    = 1'b0;
        w_winner = 2'd0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int s;
            s = int'(r_last_grant) + k;
            if (s >= NUM_CH) begin
                s = s - NUM_CH;
            end
            for (int j = 0; j < NUM_CH; j++) begin
                if (!w_any && (j == s) && bus.req_valid[j]) begin
                    w_any    = 1'b1;
                    w_winner = 2'(j);
                end
            end
        end
    end

    always_comb begin
        w_sample = 8'd0;
        for (int j = 0; j < NUM_CH; j++) begin
            bus.req_ready[j] = (r_state == S_IDLE) && !i_rst && w_any && (w_winner == 2'(j));
            if (w_winner == 2'(j)) begin
                w_sample = bus.req_data[8*j +: 8];
            end
        end
    end

    // -128 negates to itself in 8 bits, which still yields a ones count of 1.
    assign w_abs  = w_sample[7] ? (~w_sample + 8'd1) : w_sample;
    assign w_fire = |(bus.req_valid & bus.req_ready);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_fire) w_next_state = S_COUNT;
            S_COUNT: if (r_cnt == 3'd7) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 2'(NUM_CH - 1);
            r_shift      <= 8'd0;
            r_acc        <= 4'd0;
            r_cnt        <= 3'd0;
            r_gi_value   <= 4'd0;
            r_gi_channel <= 2'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        r_last_grant <= w_winner;
                        r_shift      <= w_abs;
                        r_acc        <= 4'd0;
                        r_cnt        <= 3'd0;
                    end
                end
                S_COUNT: begin
                    r_acc   <= r_acc + {3'd0, r_shift[0]};
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_cnt   <= r_cnt + 3'd1;
                    // Final sum is registered here so it is already on the outputs in DONE.
                    if (r_cnt == 3'd7) begin
                        r_gi_value   <= r_acc + {3'd0, r_shift[0]};
                        r_gi_channel <= r_last_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gi_valid   = (r_state == S_DONE);
    assign bus.gi_value   = r_gi_value;
    assign bus.gi_channel = r_gi_channel;
    assign bus.busy       = (r_state != S_IDLE);

`ifdef GI_ALARM_EN
    logic [2:0] r_alarm_cnt [NUM_CH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < NUM_CH; j++) begin
                r_alarm_cnt[j] <= 3'd0;
            end
        end else if (r_state == S_DONE) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (r_gi_channel == 2'(j)) begin
                    if (r_gi_value >= ALARM_THRESH) begin
                        if (r_alarm_cnt[j] != 3'(ALARM_COUNT)) begin
                            r_alarm_cnt[j] <= r_alarm_cnt[j] + 3'd1;
                        end
                    end else begin
                        r_alarm_cnt[j] <= 3'd0;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_CH; j++) begin
            bus.alarm[j] = (r_alarm_cnt[j] == 3'(ALARM_COUNT));
        end
    end
`else
    assign bus.alarm = '0;
`endif
endmodule

// File: doc/glycemic_index_scheduler.md
# glycemic_index_scheduler

Shares one bit-serial glycemic-index engine (absolute value, then ones count) between several blood-sensor channels. The block arbitrates round-robin over the channels and accepts one 8-bit two's-complement sample per handshake. It computes the 4-bit glycemic index over 8 serial cycles and reports the result tagged with its channel. It sits between the sensor front-ends and the monitoring and alarm logic, and takes the place of one combinational calculator per channel.

## Interface
- `NUM_CH`, 2, number of sensor channels (2..4).
- `ALARM_THRESH`, 4'd6, glycemic index at or above which a result counts as high.
- `ALARM_COUNT`, 3, consecutive high results per channel needed to raise that channel's alarm (1..7).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_CH  channel i has a sample pending.
- `req_data`  in  8*NUM_CH  channel i sample at [8i+7:8i], two's complement.
- `req_ready`  out  NUM_CH  one-hot grant; a sample transfers when `req_valid[i] && req_ready[i]`.
- `gi_valid`  out  1  one-cycle pulse, result available.
- `gi_value`  out  4  glycemic index (0..8).
- `gi_channel`  out  2  channel the result belongs to.
- `busy`  out  1  high whenever the state is not IDLE.
- `alarm`  out  NUM_CH  per-channel sustained-high flag.

## Operation
- FSM states: IDLE, COUNT, DONE.
- **IDLE**
  - `req_ready` is asserted combinationally for the round-robin winner only, and only in IDLE.
  - The search order starts at `last_grant+1` and wraps modulo NUM_CH.
  - On handshake:
    - `last_grant` <= winner.
    - Shift register <= |sample|.
    - Accumulator <= 0.
    - Bit counter <= 0.
    - Next state is COUNT.
  - With no `req_valid` bit set, the FSM stays in IDLE.
- **Absolute value rule**
  - Negative samples are two's-complement negated, truncated to 8 bits.
  - -128 (8'h80) maps to 8'h80, giving index 1.
  - 0 gives index 0.
  - -1 gives 8'h01, index 1.
- **COUNT**
  - Each cycle: accumulator += shift[0]; shift register shifts right by 1; bit counter increments.
  - After exactly 8 cycles the FSM goes to DONE. There is no early termination.
- **DONE**
  - `gi_valid`=1 for this cycle only.
  - `gi_value` = accumulator; `gi_channel` = latched grant.
  - Next state is IDLE.
- `gi_value` and `gi_channel` hold the last result until the next DONE.
- Requesters must keep `req_data` stable while `req_valid` is high and unserved. The sample is captured only at the handshake edge, so later changes do not affect an in-flight computation.
- **Reset**
  - `rst` forces IDLE on the next edge and drops any in-flight sample; no `gi_valid` is produced for it.
  - `last_grant` resets to NUM_CH-1, so channel 0 wins the first arbitration.

## Timing
- Reset values:
  - `req_ready`=0 while `rst` is high.
  - `gi_valid`=0, `gi_value`=0, `gi_channel`=0, `busy`=0, `alarm`=0.
  - All alarm counters reset to 0.
- Latency: handshake in cycle 0, COUNT in cycles 1..8, `gi_valid` high in cycle 9.
- Throughput: one sample per 10 cycles. The next handshake can occur at the earliest in cycle 10.
- `busy` is high in cycles 1..9.
- Simultaneous requests are served strictly round-robin. A channel holding `req_valid` continuously waits at most NUM_CH-1 services.

## Configuration
- Macro `GI_ALARM_EN`.
- **Defined:**
  - Each channel has a saturating counter (0..ALARM_COUNT), updated in the DONE cycle for `gi_channel`.
  - If `gi_value >= ALARM_THRESH` the counter increments, saturating; otherwise it clears to 0.
  - `alarm[i]` = (counter_i == ALARM_COUNT), registered, so it is visible the cycle after DONE.
  - Other channels' counters are unaffected.
- **Undefined:**
  - No alarm counters are built.
  - The `alarm` port remains and is tied to 0.

## Test plan
- Channel 0 only, sample 8'hF0 (-16 → 8'h10):
  - Handshake in cycle 0.
  - `gi_valid` in cycle 9 with `gi_value`=1, `gi_channel`=0.
  - `busy` high in cycles 1..9 only.
- Edge samples on channel 1:
  - 8'h80 → 1.
  - 8'h7F → 7.
  - 8'h00 → 0.
  - 8'hFF → 1.
- Both channels valid continuously after reset:
  - Grants go 0,1,0,1 with handshakes at cycles 0, 10, 20, 30.
  - `req_ready` is never asserted during COUNT or DONE.
- `rst` pulsed in cycle 4 of a computation:
  - No `gi_valid` for that sample.
  - Outputs return to reset values.
  - Channel 0 wins the next arbitration.
- `GI_ALARM_EN` defined, defaults, channel 1 fed 8'h3F (index 6) three times:
  - `alarm[1]` rises the cycle after the third DONE.
  - A following 8'h01 clears it.
  - `alarm[0]` stays 0 throughout.
- `GI_ALARM_EN` undefined, same stimulus: `alarm` stays 0.
